uart_rx_core: RTL

//  UART receiver for the 8N1 serial line produced by the transmit FSM. Oversamples rx_line

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 49 ++++
 rtl/uart_rx_core.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state codes, default frame geometry and the
// mid-bit sample point.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned MID_DEF        = OVERSAMPLE_DEF / 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for rx_line plus a 3-sample majority voter centred on the
// mid-bit tick (samples at M-1 and M are held, the third is the live rx_s at M+1).
module uart_rx_sync #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk_50mhz,
  input  logic                          rst_n,
  input  logic                          rx_sample_tick,
  input  logic                          rx_line,
  input  logic [$clog2(OVERSAMPLE)-1:0] tick_ctr,
  output logic                          rx_s,
  output logic                          vote
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam logic [CW-1:0] CTR_SMP0 = CW'(M - 1);
  localparam logic [CW-1:0] CTR_SMP1 = CW'(M);

  logic       meta_q, meta_d;
  logic       rx_s_q, rx_s_d;
  logic [1:0] smp_q, smp_d;

  always_comb begin
    meta_d = rx_line;
    rx_s_d = meta_q;
    smp_d  = smp_q;
    if (rx_sample_tick) begin
      if (tick_ctr == CTR_SMP0) smp_d[0] = rx_s_q;
      if (tick_ctr == CTR_SMP1) smp_d[1] = rx_s_q;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      smp_q  <= '1;
    end else begin
      meta_q <= meta_d;
      rx_s_q <= rx_s_d;
      smp_q  <= smp_d;
    end
  end

  assign rx_s = rx_s_q;
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: oversampled start/data/stop FSM with a valid/ack output
// handshake, framing-error and sticky overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic                 rx_sample_tick,
  input  logic                 rx_line,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CTR_VOTE = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CTR_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        tick_ctr_q, tick_ctr_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_overrun_q, rx_overrun_d;
  logic                 rx_s;
  logic                 vote;
  logic                 byte_done;

  uart_rx_sync #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sync (
    .clk_50mhz     (clk_50mhz),
    .rst_n         (rst_n),
    .rx_sample_tick(rx_sample_tick),
    .rx_line       (rx_line),
    .tick_ctr      (tick_ctr_q),
    .rx_s          (rx_s),
    .vote          (vote)
  );

  always_comb begin
    state_d    = state_q;
    tick_ctr_d = tick_ctr_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_done  = 1'b0;
    if (rx_sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          tick_ctr_d = '0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          tick_ctr_d = tick_ctr_q + 1'b1;
          if (tick_ctr_q == CTR_VOTE && vote) begin
            state_d = ST_IDLE;
          end else if (tick_ctr_q == CTR_LAST) begin
            state_d    = ST_DATA;
            tick_ctr_d = '0;
            bit_idx_d  = '0;
          end
        end
        ST_DATA: begin
          tick_ctr_d = tick_ctr_q + 1'b1;
          if (tick_ctr_q == CTR_VOTE) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (tick_ctr_q == CTR_LAST) begin
            tick_ctr_d = '0;
            if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
            else bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        ST_STOP: begin
          tick_ctr_d = tick_ctr_q + 1'b1;
          // Leave at mid-stop so a start bit immediately following is not missed.
          if (tick_ctr_q == CTR_VOTE) begin
            byte_done  = 1'b1;
            state_d    = ST_IDLE;
            tick_ctr_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    rx_frame_err_d = rx_frame_err_q;
    rx_overrun_d   = rx_overrun_q;
    if (rx_ack && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
    // A completing byte wins over a same-cycle ack; only an unacked overwrite is an overrun.
    if (byte_done) begin
      rx_data_d      = shift_q;
      rx_frame_err_d = ~vote;
      rx_valid_d     = 1'b1;
      if (rx_valid_q && !rx_ack) rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tick_ctr_q     <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_ctr_q     <= tick_ctr_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_overrun_q   <= rx_overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule
